// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the mux scan sampler
package mux_scan_pkg;
  localparam int NUM_CH = 4;
  localparam int SEL_W = 2;
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
endpackage

// File: rtl/mux_scan_sampler_settle_timer.sv
// settle_timer: loadable 8-bit down-counter flagging when it reaches zero
module settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);
  logic [7:0] cnt_q, cnt_d;
  // load wins; otherwise count down and park at zero
  always_comb cnt_d = load ? value : (cnt_q != 8'd0 ? cnt_q - 8'd1 : cnt_q);
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign done = cnt_q == 8'd0;
endmodule

// File: rtl/mux_scan_sampler.sv
// mux_scan_sampler: steps the 4:1 mux selects, samples w after settling, hands out the word
import mux_scan_pkg::*;
module mux_scan_sampler #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              w_in,
  output logic              s0,
  output logic              s1,
  output logic [NUM_CH-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              busy
);
  localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  state_t state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [NUM_CH-1:0] shadow_q, shadow_d, data_q, data_d;
  logic valid_q, valid_d, load, done;
  settle_timer u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(RELOAD),
    .done (done)
  );
  // next state: a select change always reloads the settle timer
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    valid_d  = valid_q;
    load     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SETTLE;
        sel_d   = '0;
        load    = 1'b1;
      end
      SETTLE: if (done) state_d = SAMPLE;
      SAMPLE: begin
        shadow_d[sel_q] = w_in;
        if (sel_q == LAST) begin
          data_d  = shadow_d;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          sel_d   = sel_q + 1'b1;
          load    = 1'b1;
          state_d = SETTLE;
        end
      end
      HOLD: if (ready) begin
        valid_d = 1'b0;
        state_d = start ? SETTLE : IDLE;
        if (start) begin
          sel_d = '0;
          load  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state, select, shadow and output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
    end
  assign s0       = sel_q[0];
  assign s1       = sel_q[1];
  assign data_out = data_q;
  assign valid    = valid_q;
  assign busy     = state_q != IDLE;
endmodule

// File: tb/tb_mux_scan_sampler.sv
// tb_mux_scan_sampler: random and directed checks against a scan-schedule model
module tb_mux_scan_sampler;
  localparam int S = 4;
  localparam int P = S + 1;
  logic clk = 0, rst_n = 0, start = 0, ready = 1, start1 = 0, ready1 = 1;
  logic [3:0] inp = 0, inp1 = 0, dout, dout1;
  logic s0, s1, valid, busy, s0_1, s1_1, valid1, busy1, w0, w1_q;
  int vec = 0, miss = 0;
  always #5 clk = ~clk;
  assign w0 = inp[{s1, s0}];
  always @(posedge clk or negedge rst_n)
    if (!rst_n) w1_q <= 1'b0;
    else w1_q <= inp1[{s1_1, s0_1}];
  mux_scan_sampler #(.SETTLE_CYCLES(S)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .w_in(w0), .s0(s0), .s1(s1),
    .data_out(dout), .valid(valid), .ready(ready), .busy(busy));
  mux_scan_sampler #(.SETTLE_CYCLES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .w_in(w1_q), .s0(s0_1), .s1(s1_1),
    .data_out(dout1), .valid(valid1), .ready(ready1), .busy(busy1));
  int mt = -1;
  logic mhold = 0, mvalid = 0;
  logic [1:0] msel = 0;
  logic [3:0] mword = 0, mdata = 0;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mt <= -1; mhold <= 0; mvalid <= 0; msel <= 0; mword <= 0; mdata <= 0;
    end else if (mt < 0) begin
      if (start) begin mt <= 0; msel <= 0; end
    end else if (mhold) begin
      if (ready) begin
        mvalid <= 0; mhold <= 0;
        if (start) begin mt <= 0; msel <= 0; end
        else mt <= -1;
      end
    end else begin
      mt <= mt + 1;
      if ((mt + 1) % P == 0) begin
        mword[(mt + 1) / P - 1] <= inp[(mt + 1) / P - 1];
        if ((mt + 1) / P == 4) begin
          mdata <= {inp[3], mword[2:0]}; mvalid <= 1; mhold <= 1;
        end else msel <= 2'((mt + 1) / P);
      end
    end
  always @(negedge clk) begin
    vec++;
    if ({s1, s0} !== msel || dout !== mdata || valid !== mvalid || busy !== (mt >= 0)) begin
      miss++;
      $display("FAIL model @%0t got sel=%b%b data=%b valid=%b busy=%b exp sel=%b data=%b valid=%b busy=%b",
               $time, s1, s0, dout, valid, busy, msel, mdata, mvalid, mt >= 0);
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 60) begin tick(); n++; end
  endtask
  task automatic wait_valid1(output int n);
    n = 0;
    while (!valid1 && n < 60) begin tick(); n++; end
  endtask
  initial begin
    int n;
    bit seen;
    repeat (3) tick();
    chk("reset_state", {28'd0, s1, s0, valid, busy}, 0);
    chk("reset_data", dout, 0);
    rst_n = 1;
    tick();
    inp = 4'b1110;
    start = 1; tick(); start = 0;
    n = 0;
    while (!valid && n < 60) begin
      if (n % 5 == 0 && n < 20) chk("sel_seq", {s1, s0}, n / 5);
      tick(); n++;
    end
    chk("latency", n, 20);
    chk("word1", dout, 4'b1110);
    tick();
    chk("handshake_valid", valid, 0);
    chk("handshake_busy", busy, 0);
    chk("keep_data", dout, 4'b1110);
    ready = 0; inp = 4'b0001;
    start = 1; tick(); start = 0;
    wait_valid(n);
    chk("latency_bp", n, 20);
    for (int i = 0; i < 30; i++) begin
      start = (i == 10);
      tick();
      chk("bp_data", dout, 4'b0001);
      chk("bp_valid", valid, 1);
      chk("bp_busy", busy, 1);
    end
    inp = 4'b0110; ready = 1; start = 1; tick(); start = 0;
    chk("b2b_drop", valid, 0);
    chk("b2b_busy", busy, 1);
    wait_valid(n);
    chk("b2b_gap", n, 20);
    chk("b2b_word", dout, 4'b0110);
    tick();
    inp = 4'b1010;
    start = 1; tick(); start = 0;
    repeat (14) tick();
    #2 rst_n = 0;
    #1;
    chk("async_rst", {s1, s0, valid, busy}, 0);
    chk("async_rst_data", dout, 0);
    tick(); tick();
    rst_n = 1;
    seen = 0;
    repeat (30) begin tick(); if (valid) seen = 1; end
    chk("no_valid_after_rst", seen, 0);
    start = 1; tick(); start = 0;
    wait_valid(n);
    chk("post_rst_latency", n, 20);
    chk("post_rst_word", dout, 4'b1010);
    tick();
    for (int i = 0; i < 1500; i++) begin
      if (!busy || valid) inp = 4'($urandom);
      ready = $urandom_range(0, 3) != 0;
      start = $urandom_range(0, 3) == 0;
      tick();
    end
    start = 0; ready = 1;
    repeat (30) tick();
    inp1 = 4'b0001;
    start1 = 1; tick(); start1 = 0;
    wait_valid1(n);
    chk("s1_latency", n, 8);
    chk("s1_word0", dout1, 4'b0001);
    tick();
    inp1 = 4'b0010;
    start1 = 1; tick(); start1 = 0;
    wait_valid1(n);
    chk("s1_latency2", n, 8);
    chk("s1_word1", dout1, 4'b0010);
    tick();
    chk("s1_idle", busy1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
